// File: rtl/svlib_skid_pkg.sv
// Shared types and helpers for the flushable two-entry skid buffer.
package svlib_skid_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Number of beats held in a given state; this is what a flush discards.
  function automatic logic [1:0] skid_occupancy(input skid_state_e st);
    case (st)
      SKID_BUSY: skid_occupancy = 2'd1;
      SKID_FULL: skid_occupancy = 2'd2;
      default:   skid_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/register_en_sync_rstn.sv
// Enabled data register with synchronous active-low reset and synchronous clear.
module register_en_sync_rstn #(
  parameter int          WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Reset and clear both return to RESET_VAL; otherwise load only when enabled.
  always_ff @(posedge clk) begin
    if (!rstn || clr) dout <= RESET_VAL;
    else if (en)      dout <= din;
  end

endmodule

// File: rtl/skid_buffer_flush_sync_rstn.sv
// Two-entry valid/ready skid buffer with flush and a saturating drop counter.
//
// state      | meaning
// -----------+----------------------------------------------
// SKID_EMPTY | nothing held; s_ready=1, m_valid=0
// SKID_BUSY  | main holds one beat; s_ready=1, m_valid=1
// SKID_FULL  | main and skid hold beats; s_ready=0, m_valid=1
module skid_buffer_flush_sync_rstn
  import svlib_skid_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  skid_state_e          state_q, state_d;
  logic                 s_ready_q;
  logic [WIDTH-1:0]     main_q, skid_q, main_din;
  logic                 main_en, skid_en;
  logic                 in_xfer, out_xfer;
  logic [CNT_WIDTH:0]   drop_sum;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  // Flush is the only combinational input-to-output path.
  assign s_ready  = s_ready_q & ~flush;
  assign m_valid  = (state_q != SKID_EMPTY) & ~flush;
  assign m_data   = flush ? '0 : main_q;
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;
  assign drop_cnt = drop_cnt_q;

  // Next state and data-register capture selection.
  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_din = s_data;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (in_xfer) begin
          state_d = SKID_BUSY;
          main_en = 1'b1;
        end
        SKID_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer) begin
            state_d = SKID_FULL;
            skid_en = 1'b1;
          end else if (out_xfer) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: if (out_xfer) begin
          state_d  = SKID_BUSY;
          main_en  = 1'b1;
          main_din = skid_q;
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // State and registered s_ready; s_ready tracks the next state so m_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= SKID_EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != SKID_FULL);
    end
  end

  // Sum is one bit wider than the counter so overflow is visible before clamping.
  assign drop_sum = {1'b0, drop_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, skid_occupancy(state_q)};

  // Saturating count of beats discarded by flush; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!rstn)           drop_cnt_q <= '0;
    else if (flush) begin
      if (drop_sum[CNT_WIDTH]) drop_cnt_q <= '1;
      else                     drop_cnt_q <= drop_sum[CNT_WIDTH-1:0];
    end
  end

  register_en_sync_rstn #(.WIDTH(WIDTH), .RESET_VAL('0)) u_main_reg (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .en   (main_en),
    .din  (main_din),
    .dout (main_q)
  );

  register_en_sync_rstn #(.WIDTH(WIDTH), .RESET_VAL('0)) u_skid_reg (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .en   (skid_en),
    .din  (s_data),
    .dout (skid_q)
  );

endmodule

// File: doc/skid_buffer_flush_sync_rstn.md
# skid_buffer_flush_sync_rstn

Two-entry valid/ready skid buffer with pipeline flush. It sits directly upstream of the enable/flush pipeline registers: it absorbs one beat of downstream back-pressure and produces a clean `m_valid`/`m_data` pair whose handshake (`m_valid & m_ready`) drives the downstream register enable. It breaks the combinational `ready` path: `s_ready` is a register output. It also counts beats discarded by flush for debug.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `CNT_WIDTH`, 8: width of the flush-drop counter (≥2).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `flush` input 1: discards all held beats; takes priority over every handshake.
- `s_valid` input 1: upstream beat valid.
- `s_ready` output 1: buffer can accept a beat; registered.
- `s_data` input WIDTH: upstream payload.
- `m_valid` output 1: downstream beat valid.
- `m_ready` input 1: downstream accepts.
- `m_data` output WIDTH: downstream payload.
- `drop_cnt` output CNT_WIDTH: saturating count of beats discarded by flush.

## Operation
- Storage consists of a main register (`main_data`, `main_vld`) and a skid register (`skid_data`, `skid_vld`). `m_data` is driven from main only.
- Definitions:
  - `in_xfer = s_valid & s_ready & ~flush`
  - `out_xfer = m_valid & m_ready` (`m_valid` is already gated by flush)
- FSM states and outputs:
  - EMPTY: `s_ready=1`, `m_valid=0`.
  - BUSY (main valid): `s_ready=1`, `m_valid=1`.
  - FULL (main and skid valid): `s_ready=0`, `m_valid=1`.
- Transitions when `flush=0`:
  - EMPTY, `in_xfer`: go to BUSY, `main_data<=s_data`.
  - BUSY, `in_xfer & out_xfer`: stay BUSY, `main_data<=s_data`.
  - BUSY, `in_xfer & ~out_xfer`: go to FULL, `skid_data<=s_data`.
  - BUSY, `~in_xfer & out_xfer`: go to EMPTY.
  - FULL, `out_xfer`: go to BUSY, `main_data<=skid_data`. No input is accepted because `s_ready=0`.
  - All other cases: hold.
- Flush:
  - While `flush=1`, `m_valid`, `m_data` and `s_ready` are forced to 0 combinationally. No transfer occurs on either side.
  - At the edge, the state goes to EMPTY and both data registers clear to 0.
  - `drop_cnt <= min(drop_cnt + occ, 2^CNT_WIDTH-1)`, where `occ` is 0/1/2 for EMPTY/BUSY/FULL.
  - Width rule: the sum is computed at CNT_WIDTH+1 bits, then clamped.
- Data registers load only on their capture conditions above. They hold otherwise.
- AXI-style rules:
  - Once `m_valid=1` with `flush=0`, `m_data` is held stable until `out_xfer` or flush.
  - `m_valid` never drops without `out_xfer`, except under flush.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.

## Timing
- Reset (`rstn=0` at an edge) gives:
  - state EMPTY
  - `main_data=skid_data=0`
  - `drop_cnt=0`
  - hence `m_valid=0`, `m_data=0`, `s_ready=1`.
- Reset has priority over flush. `drop_cnt` does not count when reset and flush are both asserted.
- Reset mid-operation discards held beats without counting them.
- Latency is 1 cycle: a beat accepted at edge N appears on `m_*` after edge N.
- Throughput is 1 beat/cycle with `m_ready` held high.
- `s_ready` deasserts in the cycle after the first stalled accept, i.e. the BUSY→FULL edge. It reasserts in the cycle after the FULL→BUSY drain.
- No combinational path from `m_ready` to `s_ready`. The only combinational input-to-output paths are from `flush` to the gated outputs.
- `flush` and `s_valid` in the same cycle: the beat is not accepted and not counted.
- `drop_cnt` saturates at all-ones and stays there until reset.

## Structure
- Shared package `svlib_skid_pkg`: typedef enum `skid_state_e {SKID_EMPTY, SKID_BUSY, SKID_FULL}`, 2-bit encoding.
- Natural sub-module: `register_en_sync_rstn`, two instances, for `main_data` and `skid_data`. `RESET_VAL` is 0. Enable and din muxing are done in this block.
- The FSM, flush gating and drop counter are local logic.

## Test plan
- **Reset:** hold `rstn=0` for 3 cycles with `s_valid=1`, `s_data=0xA5`. Then check `m_valid=0`, `m_data=0`, `s_ready=1`, `drop_cnt=0`, and that no beat is accepted.
- **Streaming:** `m_ready=1`, `s_valid=1`, data 1..8 on consecutive cycles. Check `m_data` is 1..8 one cycle later, back-to-back, and `s_ready` stays 1.
- **Back-pressure:**
  - Send 0x11, 0x22, 0x33 with `m_ready=0`.
  - Check 0x11 and 0x22 are held, with the state in FULL.
  - Check `s_ready=0` after the second edge, and that 0x33 is presented with `s_ready=0` so it is not accepted.
  - Raise `m_ready` and check the outputs are 0x11 then 0x22, followed by 0x33 once it is re-accepted.
- **Flush while FULL:**
  - Fill with 0x11 and 0x22, then pulse `flush` for 1 cycle.
  - During the pulse, check `m_valid=0`, `m_data=0`, `s_ready=0`.
  - Afterwards check the state is EMPTY and `drop_cnt=2`.
  - Flush again while BUSY and check `drop_cnt=3`.
- **Simultaneous events:**
  - In BUSY with `in_xfer` and `out_xfer` together, check the state stays BUSY and the new data appears next cycle.
  - `flush` and `s_valid` together: check the beat is dropped and not counted.
  - `rstn=0` and `flush=1` together: check `drop_cnt` is unchanged at 0.
- **Saturation:** with `CNT_WIDTH=2`, flush while FULL twice. Check `drop_cnt=3` after the second flush and that it stays at 3 on further flushes.
